apb_cmd_sequencer: RTL and testbench
====================================

// Module: apb_cmd_sequencer
// PURPOSE
//  Upstream master for the APB coefficient/config subsystem. Buffers host commands (write/read,
//  one-hot component select, address, coefficient) in a FIFO. Replays each as one master transfer
//  on the MTRANS/MWRITE/MSELx/MADDR/MWDATA/MRDATA interface, using fixed transfer spacing.
//  Returns read data to the host as a response pulse.
// PARAMETERS
//  ADDR_WIDTH   7   address width (MADDR)
//  COEFF_WIDTH  20  signed write-data width (MWDATA)
//  PDATA_WIDTH  32  read-data width (MRDATA)
//  COMP         4   number of one-hot component selects (MSELx)
//  FIFO_DEPTH   8   command FIFO entries; power of 2, >=2
//  XFER_CYC     4   cycles per transfer incl. issue cycle; >=2
// PORTS
//  clk         in   1                clock
//  rst_n       in   1                synchronous active-low reset
//  cmd_valid   in   1                host command valid
//  cmd_ready   out  1                FIFO can accept; = !full
//  cmd_write   in   1                1=write, 0=read
//  cmd_sel     in   COMP             one-hot target (0 FRAC_DECI, 1 IIR, 2 CTRL, 3 CIC)
//  cmd_addr    in   ADDR_WIDTH       register/coeff address
//  cmd_wdata   in   COEFF_WIDTH      signed write data
//  rsp_valid   out  1                1-cycle pulse, read data valid; no backpressure
//  rsp_data    out  PDATA_WIDTH      read data
//  busy        out  1                FSM not IDLE or FIFO non-empty
//  fifo_count  out  $clog2(D+1)      FIFO occupancy
//  bad_sel     out  1                1-cycle pulse: accepted cmd had non-one-hot cmd_sel, dropped
//  vfy_err     out  1                1-cycle pulse on readback mismatch (macro only, else 0)
//  vfy_err_cnt out  8                saturating mismatch count (macro only, else 0)
//  MTRANS      out  1                transfer start strobe
//  MWRITE      out  1                direction
//  MSELx       out  COMP             component select
//  MADDR       out  ADDR_WIDTH       address
//  MWDATA      out  COEFF_WIDTH      write data (signed)
//  MRDATA      in   PDATA_WIDTH      read data from subsystem
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all outputs 0, FIFO empty, FSM IDLE, counters 0.
//   Reset mid-transfer aborts it: MTRANS/MSELx drop next edge; queued cmds lost.
//  Input: handshake on cmd_valid&cmd_ready. Non-one-hot cmd_sel (incl. 0) is consumed and not queued;
//   bad_sel pulses the next cycle. Push+pop in one cycle keeps count. No push when full.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE:
//   IDLE:  FIFO non-empty -> pop head into cmd regs, go ISSUE. MTRANS=0, MSELx=0.
//   ISSUE: MTRANS=1 for exactly one cycle. MWRITE/MSELx/MADDR/MWDATA come from cmd regs.
//          Load cnt=XFER_CYC-2, go WAIT.
//   WAIT:  MTRANS=0. MWRITE/MSELx/MADDR/MWDATA held stable.
//          At cnt==0: reads register MRDATA into rsp_data and pulse rsp_valid, then go IDLE.
//          Otherwise decrement cnt.
//  Per-cmd cost XFER_CYC+1 cycles; first MTRANS 2 cycles after accept into empty FIFO.
//  MWDATA for reads = 0. rsp_data holds last read value until the next read.
// CONFIGURATION
//  APB_SEQ_VERIFY_EN defined:
//   - each write is followed by an automatic read of the same sel/addr (extra ISSUE/WAIT pass, no rsp_valid).
//   - MRDATA[COEFF_WIDTH-1:0] != written data -> vfy_err pulse, vfy_err_cnt++ (saturates at 255).
//  APB_SEQ_VERIFY_EN undefined: no readback pass; vfy_err and vfy_err_cnt tied 0.
// STRUCTURE
//  apb_seq_pkg:
//   - typedef enum {IDLE,ISSUE,WAIT,VFY_ISSUE,VFY_WAIT} seq_state_e
//   - typedef struct packed {write, sel, addr, wdata} seq_cmd_t
//   - function is_onehot()
//  Sub-module apb_seq_fifo: sync FIFO of seq_cmd_t, registered count, full/empty flags.
// TESTING
//  1 Write sel=0001 addr=0x05 data=0x7FFFF -> one MTRANS pulse, MWRITE=1, MSELx=0001;
//    MADDR/MWDATA stable 4 cycles.
//  2 Read sel=0100 addr=0x02 with MRDATA=0xDEADBEEF -> rsp_valid 1 cycle, rsp_data=0xDEADBEEF,
//    5 cycles after the cmd reaches the FIFO head.
//  3 Burst 10 cmds, FIFO_DEPTH 8, host never stalls -> cmd_ready low at count 8;
//    all 10 issued in order, MTRANS spacing 5.
//  4 cmd_sel=0011 then 0000 -> two bad_sel pulses, no MTRANS, fifo_count stays 0.
//  5 Assert rst_n=0 in WAIT of a write with 3 queued -> all outputs 0 next edge;
//    no MTRANS after release until a new cmd.
//  6 VERIFY_EN: write 0x12345, MRDATA returns 0x12344 -> vfy_err pulse, vfy_err_cnt=1, no rsp_valid.

Source files
------------

// File: rtl/apb_seq_pkg.sv
// -----------------------------------------------------------------------------
// apb_seq_pkg
//  Shared types for the APB command sequencer: FSM state encoding, the queued
//  command record, and the one-hot select check used at the host interface.
//  The command record widths track the sequencer's default parameters.
// -----------------------------------------------------------------------------
package apb_seq_pkg;

  localparam int SEQ_ADDR_W  = 7;
  localparam int SEQ_COEFF_W = 20;
  localparam int SEQ_COMP    = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    VFY_ISSUE,
    VFY_WAIT
  } seq_state_e;

  typedef struct packed {
    logic                          write;
    logic [SEQ_COMP-1:0]           sel;
    logic [SEQ_ADDR_W-1:0]         addr;
    logic signed [SEQ_COEFF_W-1:0] wdata;
  } seq_cmd_t;

  // True when exactly one bit is set (zero is not one-hot).
  function automatic logic is_onehot(input logic [SEQ_COMP-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/apb_seq_fifo.sv
// -----------------------------------------------------------------------------
// apb_seq_fifo
//  Synchronous FIFO for sequencer commands with a registered occupancy count.
//  Head entry is presented combinationally on o_dout while not empty.
// Ports
//  clk, rst_n       clock, synchronous active-low reset
//  i_push, i_din    write strobe / data (ignored when full)
//  i_pop            read strobe (ignored when empty)
//  o_dout           head entry
//  o_full, o_empty  occupancy flags
//  o_count          number of stored entries
// -----------------------------------------------------------------------------
module apb_seq_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  output logic [W-1:0]               o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// apb_cmd_sequencer
//  Host-side master for the APB coefficient/config subsystem. Host commands are
//  queued in a FIFO and replayed one at a time as a master transfer:
//  one ISSUE cycle (MTRANS high) followed by XFER_CYC-1 WAIT cycles with the
//  bus fields held, then one IDLE cycle. Reads return MRDATA as a one-cycle
//  rsp_valid pulse. Commands whose select is not one-hot are dropped and
//  flagged on bad_sel.
//
//  Optional feature macro: APB_SEQ_VERIFY_EN
//   When defined, each write is followed by a readback of the same sel/addr;
//   a mismatch on MRDATA[COEFF_WIDTH-1:0] pulses vfy_err and bumps the
//   saturating vfy_err_cnt. When undefined, vfy_err/vfy_err_cnt stay 0.
//
// Ports
//  clk, rst_n              clock, synchronous active-low reset
//  cmd_valid/cmd_ready     host command handshake (ready = FIFO not full)
//  cmd_write/sel/addr/wdata host command fields
//  rsp_valid, rsp_data     read response pulse / last read value
//  busy, fifo_count        activity flag, queue occupancy
//  bad_sel                 pulse: dropped command with invalid select
//  vfy_err, vfy_err_cnt    readback mismatch pulse / count
//  MTRANS..MWDATA, MRDATA  subsystem master transfer interface
// -----------------------------------------------------------------------------
module apb_cmd_sequencer
  import apb_seq_pkg::*;
#(
  parameter int ADDR_WIDTH  = 7,
  parameter int COEFF_WIDTH = 20,
  parameter int PDATA_WIDTH = 32,
  parameter int COMP        = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int XFER_CYC    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [COMP-1:0]                 cmd_sel,
  input  logic [ADDR_WIDTH-1:0]           cmd_addr,
  input  logic signed [COEFF_WIDTH-1:0]   cmd_wdata,
  output logic                            rsp_valid,
  output logic [PDATA_WIDTH-1:0]          rsp_data,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            bad_sel,
  output logic                            vfy_err,
  output logic [7:0]                      vfy_err_cnt,
  output logic                            MTRANS,
  output logic                            MWRITE,
  output logic [COMP-1:0]                 MSELx,
  output logic [ADDR_WIDTH-1:0]           MADDR,
  output logic signed [COEFF_WIDTH-1:0]   MWDATA,
  input  logic [PDATA_WIDTH-1:0]          MRDATA
);

`ifdef APB_SEQ_VERIFY_EN
  localparam bit VFY_EN = 1'b1;
`else
  localparam bit VFY_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(XFER_CYC);

  seq_state_e        r_state;
  seq_state_e        w_state_nx;
  seq_cmd_t          r_cmd;
  seq_cmd_t          w_din;
  seq_cmd_t          w_head;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_bad;
  logic              w_pop;
  logic              w_cap_rsp;
  logic              w_vfy_chk;
  logic              r_rsp_valid;
  logic [PDATA_WIDTH-1:0] r_rsp_data;
  logic              r_bad_sel;
  logic              r_vfy_err;
  logic [7:0]        r_vfy_cnt;

  // ---------------------------------------------------------------------------
  // Host interface and command queue
  // ---------------------------------------------------------------------------
  // Ready is held low while reset is asserted so nothing appears accepted then.
  assign cmd_ready = ~w_full & rst_n;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_push    = w_accept & is_onehot(cmd_sel);
  assign w_bad     = w_accept & ~is_onehot(cmd_sel);

  assign w_din = '{write: cmd_write, sel: cmd_sel, addr: cmd_addr, wdata: cmd_wdata};

  apb_seq_fifo #(
    .W     ($bits(seq_cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_cap_rsp  = 1'b0;
    w_vfy_chk  = 1'b0;
    MTRANS     = 1'b0;
    MWRITE     = 1'b0;
    MSELx      = '0;
    MADDR      = '0;
    MWDATA     = '0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_state_nx = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        MTRANS = (r_state == ISSUE);
        MWRITE = r_cmd.write;
        MSELx  = r_cmd.sel;
        MADDR  = r_cmd.addr;
        MWDATA = r_cmd.wdata;
        if (r_state == ISSUE) begin
          w_state_nx = WAIT;
        end else if (r_cnt == '0) begin
          w_cap_rsp  = ~r_cmd.write;
          w_state_nx = (r_cmd.write && VFY_EN) ? VFY_ISSUE : IDLE;
        end
      end
      // Readback pass: a read of the same target, write data not driven.
      VFY_ISSUE, VFY_WAIT: begin
        MTRANS = (r_state == VFY_ISSUE);
        MSELx  = r_cmd.sel;
        MADDR  = r_cmd.addr;
        if (r_state == VFY_ISSUE) begin
          w_state_nx = VFY_WAIT;
        end else if (r_cnt == '0) begin
          w_vfy_chk  = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command registers, spacing counter, responses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd       <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_bad_sel   <= 1'b0;
      r_vfy_err   <= 1'b0;
      r_vfy_cnt   <= '0;
    end else begin
      // Reads never drive write data, so it is cleared on load.
      if (w_pop) begin
        r_cmd       <= w_head;
        r_cmd.wdata <= w_head.write ? w_head.wdata : '0;
      end
      if (r_state == ISSUE || r_state == VFY_ISSUE)
        r_cnt <= CNT_W'(XFER_CYC - 2);
      else if ((r_state == WAIT || r_state == VFY_WAIT) && r_cnt != '0)
        r_cnt <= r_cnt - CNT_W'(1);
      r_rsp_valid <= w_cap_rsp;
      if (w_cap_rsp) r_rsp_data <= MRDATA;
      r_bad_sel <= w_bad;
      r_vfy_err <= w_vfy_chk &&
                   (MRDATA[COEFF_WIDTH-1:0] != $unsigned(r_cmd.wdata));
      if (w_vfy_chk && (MRDATA[COEFF_WIDTH-1:0] != $unsigned(r_cmd.wdata)) &&
          r_vfy_cnt != 8'hFF)
        r_vfy_cnt <= r_vfy_cnt + 8'd1;
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign bad_sel     = r_bad_sel;
  assign vfy_err     = r_vfy_err;
  assign vfy_err_cnt = r_vfy_cnt;
  assign busy        = (r_state != IDLE) | ~w_empty;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
module tb_apb_cmd_sequencer;

  localparam int ADDR_WIDTH  = 7;
  localparam int COEFF_WIDTH = 20;
  localparam int PDATA_WIDTH = 32;
  localparam int COMP        = 4;
  localparam int FIFO_DEPTH  = 8;
  localparam int XFER_CYC    = 4;
  localparam int CW          = $clog2(FIFO_DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [COMP-1:0]        cmd_sel;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [COEFF_WIDTH-1:0] cmd_wdata;
  logic                   rsp_valid;
  logic [PDATA_WIDTH-1:0] rsp_data;
  logic                   busy;
  logic [CW-1:0]          fifo_count;
  logic                   bad_sel;
  logic                   vfy_err;
  logic [7:0]             vfy_err_cnt;
  logic                   MTRANS;
  logic                   MWRITE;
  logic [COMP-1:0]        MSELx;
  logic [ADDR_WIDTH-1:0]  MADDR;
  logic [COEFF_WIDTH-1:0] MWDATA;
  logic [PDATA_WIDTH-1:0] MRDATA;

  apb_cmd_sequencer #(
    .ADDR_WIDTH (ADDR_WIDTH), .COEFF_WIDTH (COEFF_WIDTH), .PDATA_WIDTH (PDATA_WIDTH),
    .COMP (COMP), .FIFO_DEPTH (FIFO_DEPTH), .XFER_CYC (XFER_CYC)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
    .cmd_sel (cmd_sel), .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid), .rsp_data (rsp_data), .busy (busy),
    .fifo_count (fifo_count), .bad_sel (bad_sel), .vfy_err (vfy_err),
    .vfy_err_cnt (vfy_err_cnt), .MTRANS (MTRANS), .MWRITE (MWRITE),
    .MSELx (MSELx), .MADDR (MADDR), .MWDATA (MWDATA), .MRDATA (MRDATA)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transfer log, recorded away from the active edge.
  int                    cyc = 0;
  int                    mt_cyc[$];
  logic [ADDR_WIDTH-1:0] mt_addr[$];
  bit                    saw_full = 1'b0;
  logic                  ready_at_full = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (MTRANS === 1'b1) begin
      mt_cyc.push_back(cyc);
      mt_addr.push_back(MADDR);
    end
    if (fifo_count == CW'(FIFO_DEPTH) && !saw_full) begin
      saw_full      = 1'b1;
      ready_at_full = cmd_ready;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic                   wr;
    logic [COMP-1:0]        sel;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [COEFF_WIDTH-1:0] wdata;
    logic [PDATA_WIDTH-1:0] mrdata;
    logic [COEFF_WIDTH-1:0] exp_mwdata;
    logic                   exp_rv;
    logic [PDATA_WIDTH-1:0] exp_rd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    int rv_seen;

    tbl[0] = '{1'b1, 4'b0001, 7'h05, 20'h7FFFF, 32'h0007FFFF, 20'h7FFFF, 1'b0, 32'h00000000};
    tbl[1] = '{1'b0, 4'b0100, 7'h02, 20'h12345, 32'hDEADBEEF, 20'h00000, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 4'b1000, 7'h7F, 20'h80000, 32'h00080000, 20'h80000, 1'b0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 4'b0010, 7'h00, 20'h00000, 32'h00000000, 20'h00000, 1'b1, 32'h00000000};
    tbl[4] = '{1'b0, 4'b0001, 7'h40, 20'hABCDE, 32'hFFFFFFFF, 20'h00000, 1'b1, 32'hFFFFFFFF};
    tbl[5] = '{1'b1, 4'b0010, 7'h11, 20'hFFFFF, 32'h000FFFFF, 20'hFFFFF, 1'b0, 32'hFFFFFFFF};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sel = '0;
    cmd_addr = '0; cmd_wdata = '0; MRDATA = '0;
    tick(); tick();
    chk("rst_bus", {MTRANS, MWRITE, MSELx, MADDR, MWDATA}, 64'd0);
    chk("rst_rsp", {rsp_valid, rsp_data}, 64'd0);
    chk("rst_stat", {busy, fifo_count, bad_sel, vfy_err, vfy_err_cnt}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Single-command vectors
    for (int i = 0; i < 6; i++) begin
      MRDATA    = tbl[i].mrdata;
      cmd_write = tbl[i].wr;
      cmd_sel   = tbl[i].sel;
      cmd_addr  = tbl[i].addr;
      cmd_wdata = tbl[i].wdata;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("count_after_accept", 64'(fifo_count), 64'd1);
      chk("no_mtrans_yet", 64'(MTRANS), 64'd0);
      tick();
      chk("issue_mtrans", 64'(MTRANS), 64'd1);
      chk("issue_mwrite", 64'(MWRITE), 64'(tbl[i].wr));
      chk("issue_msel", 64'(MSELx), 64'(tbl[i].sel));
      chk("issue_maddr", 64'(MADDR), 64'(tbl[i].addr));
      chk("issue_mwdata", 64'(MWDATA), 64'(tbl[i].exp_mwdata));
      for (int c = 0; c < XFER_CYC - 1; c++) begin
        tick();
        chk("wait_mtrans", 64'(MTRANS), 64'd0);
        chk("wait_msel", 64'(MSELx), 64'(tbl[i].sel));
        chk("wait_maddr", 64'(MADDR), 64'(tbl[i].addr));
        chk("wait_mwdata", 64'(MWDATA), 64'(tbl[i].exp_mwdata));
        chk("wait_rsp_valid", 64'(rsp_valid), 64'd0);
      end
      tick();
      chk("rsp_valid", 64'(rsp_valid), 64'(tbl[i].exp_rv));
      chk("rsp_data", 64'(rsp_data), 64'(tbl[i].exp_rd));
      tick();
      chk("rsp_pulse_end", 64'(rsp_valid), 64'd0);
      wait_idle(40);
      chk("idle_msel", 64'(MSELx), 64'd0);
      chk("idle_vfy_cnt", 64'(vfy_err_cnt), 64'd0);
    end

    // Burst of 10 reads with an eager host
    MRDATA = 32'h00005A5A;
    base = mt_cyc.size();
    for (int i = 0; i < 10; i++) begin
      cmd_write = 1'b0;
      cmd_sel   = 4'b0001;
      cmd_addr  = 7'(i);
      cmd_valid = 1'b1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
        tick();
        n++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    wait_idle(200);
    chk("burst_count", 64'(mt_cyc.size() - base), 64'd10);
    chk("burst_saw_full", 64'(saw_full), 64'd1);
    chk("burst_ready_at_full", 64'(ready_at_full), 64'd0);
    for (int k = 0; k < 10; k++) begin
      if (base + k < mt_cyc.size()) begin
        chk("burst_order", 64'(mt_addr[base + k]), 64'(k));
        if (k > 0)
          chk("burst_spacing", 64'(mt_cyc[base + k] - mt_cyc[base + k - 1]), 64'd5);
      end
    end

    // Invalid selects are consumed and dropped
    base = mt_cyc.size();
    cmd_write = 1'b1; cmd_sel = 4'b0011; cmd_addr = 7'h01; cmd_wdata = 20'h00111;
    cmd_valid = 1'b1;
    tick();
    chk("bad_sel_0011", 64'(bad_sel), 64'd1);
    chk("bad_count_0011", 64'(fifo_count), 64'd0);
    cmd_sel = 4'b0000;
    tick();
    cmd_valid = 1'b0;
    chk("bad_sel_0000", 64'(bad_sel), 64'd1);
    chk("bad_count_0000", 64'(fifo_count), 64'd0);
    tick();
    chk("bad_sel_end", 64'(bad_sel), 64'd0);
    repeat (6) tick();
    chk("bad_no_mtrans", 64'(mt_cyc.size() - base), 64'd0);
    chk("bad_not_busy", 64'(busy), 64'd0);

    // Reset during WAIT of a write with three commands queued
    cmd_write = 1'b1; cmd_sel = 4'b0001; cmd_addr = 7'h0A; cmd_wdata = 20'h00ABC;
    cmd_valid = 1'b1;
    tick();
    cmd_write = 1'b0; cmd_addr = 7'h0B;
    tick();
    cmd_addr = 7'h0C;
    tick();
    cmd_addr = 7'h0D;
    tick();
    cmd_valid = 1'b0;
    chk("pre_rst_count", 64'(fifo_count), 64'd3);
    chk("pre_rst_wait", {MTRANS, MWRITE, MSELx}, {58'd0, 1'b0, 1'b1, 4'b0001});
    rst_n = 1'b0;
    tick();
    chk("midrst_bus", {MTRANS, MWRITE, MSELx, MADDR, MWDATA}, 64'd0);
    chk("midrst_rsp", {rsp_valid, rsp_data}, 64'd0);
    chk("midrst_stat", {busy, fifo_count, bad_sel, vfy_err, vfy_err_cnt}, 64'd0);
    rst_n = 1'b1;
    base = mt_cyc.size();
    repeat (10) tick();
    chk("post_rst_quiet", 64'(mt_cyc.size() - base), 64'd0);
    cmd_write = 1'b0; cmd_sel = 4'b1000; cmd_addr = 7'h21; MRDATA = 32'h0BADF00D;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_idle(40);
    chk("post_rst_new_cmd", 64'(mt_cyc.size() - base), 64'd1);
    if (mt_cyc.size() > base)
      chk("post_rst_addr", 64'(mt_addr[mt_cyc.size() - 1]), 64'h21);
    chk("post_rst_rsp", 64'(rsp_data), 64'h0BADF00D);

`ifdef APB_SEQ_VERIFY_EN
    // Readback mismatch after a write
    MRDATA = 32'h00012344;
    cmd_write = 1'b1; cmd_sel = 4'b0001; cmd_addr = 7'h03; cmd_wdata = 20'h12345;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rv_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rsp_valid === 1'b1) rv_seen++;
      if (k == 5) begin
        chk("vfy_issue_mtrans", 64'(MTRANS), 64'd1);
        chk("vfy_issue_mwrite", 64'(MWRITE), 64'd0);
        chk("vfy_issue_target", {MSELx, MADDR}, {53'd0, 4'b0001, 7'h03});
        chk("vfy_issue_mwdata", 64'(MWDATA), 64'd0);
      end
      if (k == 9) begin
        chk("vfy_err_pulse", 64'(vfy_err), 64'd1);
        chk("vfy_err_cnt", 64'(vfy_err_cnt), 64'd1);
      end
      if (k == 10) chk("vfy_err_end", 64'(vfy_err), 64'd0);
    end
    chk("vfy_no_rsp", 64'(rv_seen), 64'd0);
    wait_idle(20);
`else
    // Without readback, a write is a single pass and never flags a mismatch
    MRDATA = 32'h00012344;
    cmd_write = 1'b1; cmd_sel = 4'b0001; cmd_addr = 7'h03; cmd_wdata = 20'h12345;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    base = mt_cyc.size();
    rv_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (vfy_err !== 1'b0) rv_seen++;
    end
    chk("novfy_single_pass", 64'(mt_cyc.size() - base), 64'd1);
    chk("novfy_err", 64'(rv_seen), 64'd0);
    chk("novfy_err_cnt", 64'(vfy_err_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
